// File: rtl/bc_buffer_ctrl.sv
// bc_buffer_ctrl: sequencing controller for the breadcrumb FIFO and the serializer/deserializer.
//   Write path : ctrl_valid/ctrl_ready handshake gated by FIFO full, write reset-busy and occupancy;
//                fifo_wr_en = ctrl_valid & ctrl_ready.
//   SER path   : avoid_req -> fifo_rd_en, one settle cycle, start_ser, wait serial_done (timeout).
//   DES path   : des_req -> start_des, wait parallel_rdy (timeout), then a to_ctrl_valid pulse.
//   Status     : ser_busy, des_busy, sticky err_timeout, occupancy (words held in the FIFO).
//   clk/rst    : single rising-edge clock, synchronous active-high reset.
module bc_buffer_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned SER_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ctrl_valid,
    output logic                       ctrl_ready,
    input  logic                       fifo_full,
    input  logic                       fifo_empty,
    input  logic                       wr_rst_busy,
    input  logic                       rd_rst_busy,
    output logic                       fifo_wr_en,
    output logic                       fifo_rd_en,
    input  logic                       avoid_req,
    output logic                       start_ser,
    input  logic                       serial_done,
    input  logic                       des_req,
    output logic                       start_des,
    input  logic                       parallel_rdy,
    output logic                       to_ctrl_valid,
    output logic                       ser_busy,
    output logic                       des_busy,
    output logic                       err_timeout,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned OccW = $clog2(DEPTH) + 1;
    localparam int unsigned TmrW = $clog2(SER_TIMEOUT + 1);

    // Elaboration-time parameter sanity; DATA_W is informational only.
    if (DATA_W == 0 || DEPTH == 0 || SER_TIMEOUT == 0) begin : g_bad_params
        $error("bc_buffer_ctrl: DATA_W, DEPTH and SER_TIMEOUT must be non-zero");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_SETTLE = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4
    } ser_state_e;

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_START = 2'd1,
        D_WAIT  = 2'd2
    } des_state_e;

    ser_state_e        ser_state_q, ser_state_d;
    des_state_e        des_state_q, des_state_d;
    logic [TmrW-1:0]   ser_tmr_q, ser_tmr_d, ser_cnt;
    logic [TmrW-1:0]   des_tmr_q, des_tmr_d, des_cnt;
    logic [OccW-1:0]   occ_q, occ_d;
    logic              ser_abort, des_abort, des_done;
    logic              rd_en_q, start_ser_q, ser_busy_q;
    logic              start_des_q, des_busy_q, to_ctrl_valid_q, err_q;

    // Write gating; the occupancy term keeps the counter bounded even if fifo_full lags.
    assign ctrl_ready = !rst && !fifo_full && !wr_rst_busy && (occ_q != OccW'(DEPTH));
    assign fifo_wr_en = ctrl_valid && ctrl_ready;

    // Read FSM next state; ser_cnt counts wait cycles including the current one.
    always_comb begin
        ser_state_d = ser_state_q;
        ser_tmr_d   = ser_tmr_q;
        ser_abort   = 1'b0;
        ser_cnt     = ser_tmr_q + TmrW'(1);
        unique case (ser_state_q)
            S_IDLE: begin
                if (avoid_req && !fifo_empty && !rd_rst_busy && (occ_q != '0)) begin
                    ser_state_d = S_RD;
                end
            end
            S_RD:     ser_state_d = S_SETTLE;
            S_SETTLE: ser_state_d = S_START;
            S_START: begin
                ser_tmr_d   = '0;
                ser_state_d = S_WAIT;
            end
            S_WAIT: begin
                if (serial_done) begin
                    ser_state_d = S_IDLE;
                end else if (ser_cnt == TmrW'(SER_TIMEOUT)) begin
                    ser_abort   = 1'b1;
                    ser_state_d = S_IDLE;
                end else begin
                    ser_tmr_d = ser_cnt;
                end
            end
            default: ser_state_d = S_IDLE;
        endcase
    end

    // Deserialize FSM next state; runs independently of the read FSM.
    always_comb begin
        des_state_d = des_state_q;
        des_tmr_d   = des_tmr_q;
        des_abort   = 1'b0;
        des_done    = 1'b0;
        des_cnt     = des_tmr_q + TmrW'(1);
        unique case (des_state_q)
            D_IDLE: begin
                if (des_req) begin
                    des_state_d = D_START;
                end
            end
            D_START: begin
                des_tmr_d   = '0;
                des_state_d = D_WAIT;
            end
            D_WAIT: begin
                if (parallel_rdy) begin
                    des_done    = 1'b1;
                    des_state_d = D_IDLE;
                end else if (des_cnt == TmrW'(SER_TIMEOUT)) begin
                    des_abort   = 1'b1;
                    des_state_d = D_IDLE;
                end else begin
                    des_tmr_d = des_cnt;
                end
            end
            default: des_state_d = D_IDLE;
        endcase
    end

    // Occupancy: a simultaneous write and read cancel out.
    always_comb begin
        occ_d = occ_q;
        unique case ({fifo_wr_en, rd_en_q})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State, timers and registered outputs (decoded from next state so they align with it).
    always_ff @(posedge clk) begin
        if (rst) begin
            ser_state_q     <= S_IDLE;
            des_state_q     <= D_IDLE;
            ser_tmr_q       <= '0;
            des_tmr_q       <= '0;
            occ_q           <= '0;
            rd_en_q         <= 1'b0;
            start_ser_q     <= 1'b0;
            ser_busy_q      <= 1'b0;
            start_des_q     <= 1'b0;
            des_busy_q      <= 1'b0;
            to_ctrl_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            ser_state_q     <= ser_state_d;
            des_state_q     <= des_state_d;
            ser_tmr_q       <= ser_tmr_d;
            des_tmr_q       <= des_tmr_d;
            occ_q           <= occ_d;
            rd_en_q         <= (ser_state_d == S_RD);
            start_ser_q     <= (ser_state_d == S_START);
            ser_busy_q      <= (ser_state_d != S_IDLE);
            start_des_q     <= (des_state_d == D_START);
            des_busy_q      <= (des_state_d != D_IDLE);
            to_ctrl_valid_q <= des_done;
            err_q           <= err_q || ser_abort || des_abort;
        end
    end

    assign fifo_rd_en    = rd_en_q;
    assign start_ser     = start_ser_q;
    assign ser_busy      = ser_busy_q;
    assign start_des     = start_des_q;
    assign des_busy      = des_busy_q;
    assign to_ctrl_valid = to_ctrl_valid_q;
    assign err_timeout   = err_q;
    assign occupancy     = occ_q;

endmodule

// File: tb/tb_bc_buffer_ctrl.sv
// Testbench for bc_buffer_ctrl: directed scenarios followed by randomized traffic, all checked
// cycle by cycle against a transaction-age reference model.
module tb_bc_buffer_ctrl;

    localparam int DEPTH = 512;
    localparam int TO    = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, ctrl_valid = 1'b0, fifo_full = 1'b0, fifo_empty = 1'b1;
    logic wr_rst_busy = 1'b0, rd_rst_busy = 1'b0, avoid_req = 1'b0, serial_done = 1'b0;
    logic des_req = 1'b0, parallel_rdy = 1'b0;
    logic ctrl_ready, fifo_wr_en, fifo_rd_en, start_ser, start_des, to_ctrl_valid;
    logic ser_busy, des_busy, err_timeout;
    logic [9:0] occupancy;

    bc_buffer_ctrl #(.DATA_W(16), .DEPTH(DEPTH), .SER_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .wr_rst_busy(wr_rst_busy),
        .rd_rst_busy(rd_rst_busy), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
        .avoid_req(avoid_req), .start_ser(start_ser), .serial_done(serial_done),
        .des_req(des_req), .start_des(start_des), .parallel_rdy(parallel_rdy),
        .to_ctrl_valid(to_ctrl_valid), .ser_busy(ser_busy), .des_busy(des_busy),
        .err_timeout(err_timeout), .occupancy(occupancy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: each path is tracked by its age in cycles since acceptance (0 = idle).
    int m_occ = 0, m_ser_age = 0, m_des_age = 0;
    bit m_pulse = 0, m_err = 0;
    bit exp_ready, exp_wr, exp_rd;

    // Responders: serial_done / parallel_rdy a chosen number of cycles after each start pulse.
    int ser_delay = -1, des_delay = -1, ser_cnt = -1, des_cnt = -1;
    bit noise = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int old_occ;
        old_occ = m_occ;
        if (rst) begin
            m_occ = 0; m_ser_age = 0; m_des_age = 0; m_pulse = 0; m_err = 0;
        end else begin
            m_pulse = 0;
            if (exp_wr && !exp_rd) m_occ++;
            else if (!exp_wr && exp_rd) m_occ--;
            if (m_ser_age == 0) begin
                if (avoid_req && !fifo_empty && !rd_rst_busy && old_occ != 0) m_ser_age = 1;
            end else if (m_ser_age < 4) begin
                m_ser_age++;
            end else if (serial_done) begin
                m_ser_age = 0;
            end else if (m_ser_age - 3 == TO) begin
                m_ser_age = 0; m_err = 1;
            end else begin
                m_ser_age++;
            end
            if (m_des_age == 0) begin
                if (des_req) m_des_age = 1;
            end else if (m_des_age == 1) begin
                m_des_age = 2;
            end else if (parallel_rdy) begin
                m_des_age = 0; m_pulse = 1;
            end else if (m_des_age - 1 == TO) begin
                m_des_age = 0; m_err = 1;
            end else begin
                m_des_age++;
            end
        end
    endtask

    // One clock: drive derived inputs, check combinational outputs, clock, check registered outputs.
    task automatic cycle();
        fifo_full    = (m_occ == DEPTH);
        fifo_empty   = (m_occ == 0);
        serial_done  = (ser_cnt == 0) || (noise && $urandom_range(0, 9) == 0);
        parallel_rdy = (des_cnt == 0) || (noise && $urandom_range(0, 9) == 0);
        #2;
        exp_ready = !rst && !fifo_full && !wr_rst_busy && (m_occ != DEPTH);
        exp_wr    = ctrl_valid && exp_ready;
        exp_rd    = (m_ser_age == 1);
        chk("ctrl_ready", ctrl_ready, exp_ready);
        chk("fifo_wr_en", fifo_wr_en, exp_wr);
        @(posedge clk);
        model_step();
        #1;
        chk("fifo_rd_en", fifo_rd_en, m_ser_age == 1);
        chk("start_ser", start_ser, m_ser_age == 3);
        chk("ser_busy", ser_busy, m_ser_age != 0);
        chk("start_des", start_des, m_des_age == 1);
        chk("des_busy", des_busy, m_des_age != 0);
        chk("to_ctrl_valid", to_ctrl_valid, m_pulse);
        chk("err_timeout", err_timeout, m_err);
        chk("occupancy", occupancy, m_occ);
        if (m_ser_age == 3 && ser_delay >= 0) ser_cnt = ser_delay;
        else if (ser_cnt >= 0) ser_cnt--;
        if (m_des_age == 1 && des_delay >= 0) des_cnt = des_delay;
        else if (des_cnt >= 0) des_cnt--;
    endtask

    task automatic wait_ser_idle(input string tag);
        int n;
        n = 0;
        while (ser_busy !== 1'b0 && n < 200) begin
            cycle();
            n++;
        end
        chk(tag, ser_busy, 0);
    endtask

    initial begin
        int rd_seen;
        int n;
        #1;
        // Reset
        repeat (3) cycle();
        chk("rst_ready", ctrl_ready, 0);
        chk("rst_occ", occupancy, 0);
        rst = 1'b0;
        cycle();

        // Three writes
        ctrl_valid = 1'b1;
        repeat (3) cycle();
        ctrl_valid = 1'b0;
        chk("occ_three", occupancy, 3);
        chk("idle_after_wr", ser_busy, 0);

        // Held avoid_req drains the FIFO with the documented latencies
        ser_delay = 4;
        avoid_req = 1'b1;
        cycle();
        chk("rd_lat", fifo_rd_en, 1);
        cycle();
        chk("settle_no_rd", fifo_rd_en, 0);
        cycle();
        chk("start_lat", start_ser, 1);
        chk("occ_after_rd", occupancy, 2);
        n = 0;
        while ((occupancy !== 10'd0 || ser_busy !== 1'b0) && n < 100) begin
            cycle();
            n++;
        end
        chk("drain_occ", occupancy, 0);
        repeat (3) cycle();
        chk("idle_held_empty", ser_busy, 0);

        // Request while empty is held until a word arrives
        rd_seen = 0;
        repeat (10) begin
            cycle();
            if (fifo_rd_en === 1'b1) rd_seen++;
        end
        chk("empty_hold", rd_seen, 0);
        ctrl_valid = 1'b1;
        cycle();
        ctrl_valid = 1'b0;
        chk("occ_one", occupancy, 1);
        chk("no_rd_yet", fifo_rd_en, 0);
        cycle();
        chk("rd_after_data", fifo_rd_en, 1);
        avoid_req = 1'b0;
        wait_ser_idle("drain_one_idle");

        // Fill to DEPTH; a read at full blocks the concurrent write
        ser_delay  = 2;
        ctrl_valid = 1'b1;
        repeat (DEPTH) cycle();
        chk("occ_full", occupancy, DEPTH);
        chk("ready_full", ctrl_ready, 0);
        avoid_req = 1'b1;
        cycle();
        avoid_req = 1'b0;
        chk("rd_at_full", fifo_rd_en, 1);
        chk("ready_blocked", ctrl_ready, 0);
        cycle();
        ctrl_valid = 1'b0;
        chk("occ_511", occupancy, DEPTH - 1);
        wait_ser_idle("full_rd_idle");

        // Serializer never answers: timeout after SER_TIMEOUT wait cycles
        ser_delay = -1;
        avoid_req = 1'b1;
        cycle();
        avoid_req = 1'b0;
        cycle();
        cycle();
        chk("to_start", start_ser, 1);
        repeat (TO) cycle();
        chk("to_busy_last", ser_busy, 1);
        chk("to_err_pre", err_timeout, 0);
        cycle();
        chk("to_idle", ser_busy, 0);
        chk("to_err", err_timeout, 1);
        ser_delay  = 3;
        ctrl_valid = 1'b1;
        avoid_req  = 1'b1;
        cycle();
        ctrl_valid = 1'b0;
        avoid_req  = 1'b0;
        wait_ser_idle("post_to_idle");
        chk("err_sticky", err_timeout, 1);

        // Concurrent DES and SER transactions
        des_delay = 17;
        ser_delay = 4;
        des_req   = 1'b1;
        avoid_req = 1'b1;
        cycle();
        des_req   = 1'b0;
        avoid_req = 1'b0;
        chk("start_des", start_des, 1);
        chk("rd_conc", fifo_rd_en, 1);
        repeat (17) cycle();
        chk("tcv_pre", to_ctrl_valid, 0);
        cycle();
        chk("tcv_pulse", to_ctrl_valid, 1);
        chk("des_idle", des_busy, 0);
        wait_ser_idle("conc_ser_idle");

        // Reset in the middle of D_WAIT
        des_delay = -1;
        des_req   = 1'b1;
        cycle();
        des_req = 1'b0;
        repeat (5) cycle();
        chk("des_wait_busy", des_busy, 1);
        rst = 1'b1;
        cycle();
        chk("rst_des_busy", des_busy, 0);
        chk("rst_tcv", to_ctrl_valid, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_occ_mid", occupancy, 0);
        rst = 1'b0;
        cycle();

        // Randomized traffic
        noise = 1;
        repeat (3000) begin
            ctrl_valid  = ($urandom_range(0, 2) != 0);
            avoid_req   = ($urandom_range(0, 3) != 0);
            des_req     = ($urandom_range(0, 3) == 0);
            wr_rst_busy = ($urandom_range(0, 15) == 0);
            rd_rst_busy = ($urandom_range(0, 15) == 0);
            rst         = ($urandom_range(0, 499) == 0);
            ser_delay   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 8));
            des_delay   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 30));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
